store_rmw_unit: RTL and testbench
=================================

Name: store_rmw_unit

Overview:
- Parametrised successor to the single-cycle store merger.
- Accepts sub-word stores from the LSU and issues them to a word-wide data memory that has no byte enables.
- Partial stores run a read-modify-write sequence: read the containing word, merge the lane(s), write back. Full-width aligned stores go straight to a write.
- Sits between the MEM stage and the data RAM port. It also flags misaligned and illegal-size stores without touching memory.

Parameters:
- XLEN, 32, data and memory word width in bits; legal values are 32 or 64.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  byte address of the store.
- req_size  in  2  store size: 00 byte, 01 half, 10 word, 11 double (double legal only when XLEN=64).
- req_wdata  in  XLEN  store data, right-justified (LSBs hold the value to store).
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word-aligned address: req_addr with the low OFF=log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  merged write data.
- mem_gnt  in  1  memory accepts the current mem_req this cycle.
- mem_rvalid  in  1  read data valid; arrives 1 or more cycles after a read grant.
- mem_rdata  in  XLEN  read data.
- done  out  1  one-cycle pulse: store completed.
- err  out  1  one-cycle pulse: store rejected (misaligned or illegal size).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: asynchronous, active low. State goes to IDLE; all internal registers clear to 0.
- Output values in reset: req_ready=1; mem_req, mem_we, done, err, busy = 0; mem_addr and mem_wdata = 0.
- Handshake: a request is accepted when req_valid & req_ready. On acceptance, addr, size and wdata are captured into registers; inputs are ignored afterwards.
- Offset and size decode:
  - off = req_addr[OFF-1:0].
  - nbytes = 1 << req_size.
  - Misaligned when off mod nbytes != 0.
  - Illegal when nbytes > XLEN/8.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE, on acceptance:
  - Misaligned or illegal: go to RESP with err flagged. No memory traffic.
  - nbytes == XLEN/8: go to WR_REQ; merged data = wdata.
  - Otherwise: go to RD_REQ.
- RD_REQ: mem_req=1, mem_we=0. Hold until mem_gnt, then go to RD_WAIT.
- RD_WAIT: on mem_rvalid, build merged = mem_rdata with bytes [off .. off+nbytes-1] replaced by wdata[8*nbytes-1:0], then go to WR_REQ. A mem_rvalid that arrives in RD_REQ is ignored.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata=merged. Hold all outputs stable until mem_gnt, then go to RESP.
- RESP: exactly one of done or err is high for this single cycle; then go to IDLE.
- Outputs are driven from the registered state and data. mem_addr is stable for the whole transaction.
- Latency with mem_gnt always 1 and rvalid one cycle after grant (accept = cycle 0):
  - Partial store: RD_REQ c1, RD_WAIT c2, WR_REQ c3, done c4. Next accept c5.
  - Full store: WR_REQ c1, done c2.
  - Error: err c1.
- Back-to-back requests: req_ready returns high the cycle after RESP. Requests are never pipelined or overlapped.
- Reset mid-operation: the transaction is aborted immediately. mem_req drops asynchronously, no done pulse, no partial write is issued after reset.
- XLEN=32 with size 11: illegal, err pulse.

Test Plan:
- XLEN=32, addr 0x102, size 00, wdata 0x000000AB, memory word 0x11223344 -> read at 0x100, write 0x11AB3344, done in cycle 4.
- XLEN=32, addr 0x206, size 01, wdata 0x0000BEEF, mem 0xCAFEF00D -> write 0xBEEFF00D at 0x204. Then addr 0x205, size 01 -> err pulse, zero mem_req cycles.
- XLEN=32, addr 0x300, size 10, wdata 0xDEADBEEF -> single write at 0x300 with no read, done in cycle 2. Size 11 -> err.
- XLEN=64, addr 0x1004, size 10, wdata 0x55667788, mem 0x0011223344556677 -> write 0x5566778844556677 at 0x1000. Size 11 at 0x1008 -> direct write.
- Stalls: mem_gnt held low 3 cycles in RD_REQ and in WR_REQ, rvalid 4 cycles after grant -> outputs hold stable throughout, exactly one read, one write and one done.
- rst_n asserted while in RD_WAIT -> mem_req=0 immediately, req_ready=1, no write and no done. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/store_rmw_unit.sv
// ============================================================================
// Module   : store_rmw_unit
// Purpose  : Sub-word store merger for a data RAM without byte enables.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_rmw_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int         c_NB       = XLEN / 8;
    localparam int         c_OFF      = $clog2(c_NB);
    localparam logic [3:0] c_NB_BYTES = 4'(c_NB);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_RD_REQ  = 3'd1;
    localparam logic [2:0] c_S_RD_WAIT = 3'd2;
    localparam logic [2:0] c_S_WR_REQ  = 3'd3;
    localparam logic [2:0] c_S_RESP    = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_merged;
    logic              r_err;

    logic              w_accept;
    logic [c_OFF-1:0]  w_off;
    logic [3:0]        w_nbytes;
    logic              w_misal;
    logic              w_illegal;
    logic              w_full;
    logic              w_bad;

    logic [c_OFF-1:0]  w_roff;
    logic [3:0]        w_rnbytes;
    logic [XLEN-1:0]   w_shdata;
    logic [c_NB-1:0]   w_lane_sel;
    logic [XLEN-1:0]   w_merged;

    // Request decode on the live inputs; only meaningful in the accept cycle
    assign w_accept  = req_valid && req_ready;
    assign w_off     = req_addr[c_OFF-1:0];
    assign w_nbytes  = 4'd1 << req_size;
    assign w_misal   = ((4'(w_off) & (w_nbytes - 4'd1)) != 4'd0);
    assign w_illegal = (w_nbytes > c_NB_BYTES);
    assign w_full    = (w_nbytes == c_NB_BYTES);
    assign w_bad     = w_misal || w_illegal;

    // Lane merge: store data shifted to its byte offset overlays the read word
    assign w_roff    = r_addr[c_OFF-1:0];
    assign w_rnbytes = 4'd1 << r_size;
    assign w_shdata  = r_wdata << {w_roff, 3'b000};

    for (genvar gi = 0; gi < c_NB; gi++) begin : g_lane
        assign w_lane_sel[gi] = (4'(gi) >= 4'(w_roff)) &&
                                (4'(gi) < (4'(w_roff) + w_rnbytes));
        assign w_merged[8*gi +: 8] = w_lane_sel[gi] ? w_shdata[8*gi +: 8]
                                                    : mem_rdata[8*gi +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (w_bad)       w_next = c_S_RESP;
                    else if (w_full) w_next = c_S_WR_REQ;
                    else             w_next = c_S_RD_REQ;
                end
            end
            c_S_RD_REQ:  if (mem_gnt)    w_next = c_S_RD_WAIT;
            c_S_RD_WAIT: if (mem_rvalid) w_next = c_S_WR_REQ;
            c_S_WR_REQ:  if (mem_gnt)    w_next = c_S_RESP;
            c_S_RESP:                    w_next = c_S_IDLE;
            default:                     w_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_wdata  <= '0;
            r_merged <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_wdata  <= req_wdata;
            r_merged <= req_wdata;
            r_err    <= w_bad;
        end else if ((r_state == c_S_RD_WAIT) && mem_rvalid) begin
            r_merged <= w_merged;
        end
    end

    always_comb begin
        req_ready = (r_state == c_S_IDLE);
        busy      = (r_state != c_S_IDLE);
        mem_req   = (r_state == c_S_RD_REQ) || (r_state == c_S_WR_REQ);
        mem_we    = (r_state == c_S_WR_REQ);
        mem_addr  = {r_addr[ADDR_W-1:c_OFF], {c_OFF{1'b0}}};
        mem_wdata = r_merged;
        done      = (r_state == c_S_RESP) && !r_err;
        err       = (r_state == c_S_RESP) &&  r_err;
    end

endmodule

`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
// ============================================================================
// Module   : tb_store_rmw_unit
// Purpose  : Directed bench for store_rmw_unit (XLEN=32 and XLEN=64 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_rmw_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        done, err, busy;

    logic        req_valid_64, req_ready_64;
    logic [31:0] req_addr_64;
    logic [1:0]  req_size_64;
    logic [63:0] req_wdata_64;
    logic        mem_req_64, mem_we_64, mem_gnt_64, mem_rvalid_64;
    logic [31:0] mem_addr_64;
    logic [63:0] mem_wdata_64, mem_rdata_64;
    logic        done_64, err_64, busy_64;

    int n_vec = 0;
    int n_err = 0;

    store_rmw_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .done(done), .err(err), .busy(busy)
    );

    store_rmw_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_64), .req_ready(req_ready_64), .req_addr(req_addr_64),
        .req_size(req_size_64), .req_wdata(req_wdata_64),
        .mem_req(mem_req_64), .mem_we(mem_we_64), .mem_addr(mem_addr_64),
        .mem_wdata(mem_wdata_64), .mem_gnt(mem_gnt_64), .mem_rvalid(mem_rvalid_64),
        .mem_rdata(mem_rdata_64), .done(done_64), .err(err_64), .busy(busy_64)
    );

    // Memory model for the 32-bit instance: programmable grant stall and read latency
    int          gnt_stall = 0;
    int          rv_lat    = 1;
    logic [31:0] mem_word  = '0;
    int          stall_cnt = 0;
    int          rv_cnt    = 0;
    bit          rd_pend   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            rd_pend    = 0;
            stall_cnt  = 0;
        end else begin
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (rd_pend) begin
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word;
                    rd_pend    = 0;
                end else begin
                    rv_cnt--;
                end
            end
            if (mem_req) begin
                if (stall_cnt < gnt_stall) begin
                    stall_cnt++;
                end else begin
                    mem_gnt   = 1'b1;
                    stall_cnt = 0;
                    if (!mem_we) begin
                        rd_pend = 1;
                        rv_cnt  = rv_lat - 1;
                    end
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    int          n_rd = 0, n_wr = 0, n_done = 0, n_reqcyc = 0, n_unstable = 0;
    logic [31:0] last_raddr = '0, last_waddr = '0, last_wdata = '0;
    bit          p_hold = 0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;

    always @(negedge clk) begin
        if (mem_req) n_reqcyc++;
        if (p_hold && mem_req &&
            (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we))
            n_unstable++;
        p_hold  = mem_req && !mem_gnt;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_we    = mem_we;
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                n_wr++;
                last_waddr = mem_addr;
                last_wdata = mem_wdata;
            end else begin
                n_rd++;
                last_raddr = mem_addr;
            end
        end
        if (done) n_done++;
    end

    // 64-bit memory: always grants, read data one cycle after the grant
    logic [63:0] mem_word64 = '0;
    bit          pend64     = 0;
    int          n_rd64 = 0, n_wr64 = 0;
    logic [31:0] last_waddr64 = '0;
    logic [63:0] last_wdata64 = '0;

    always @(posedge clk) begin
        #1;
        mem_rvalid_64 = pend64;
        mem_rdata_64  = mem_word64;
        pend64        = mem_req_64 && !mem_we_64;
    end

    always @(negedge clk) begin
        if (mem_req_64 && mem_gnt_64) begin
            if (mem_we_64) begin
                n_wr64++;
                last_waddr64 = mem_addr_64;
                last_wdata64 = mem_wdata_64;
            end else begin
                n_rd64++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic store32(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                           output int cyc, output bit was_err);
        req_addr  = a;
        req_size  = s;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_size  = 2'b11;
        req_wdata = 32'hFFFF_FFFF;
        cyc       = 0;
        was_err   = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done || err) begin
                cyc     = i;
                was_err = err;
                break;
            end
        end
        @(negedge clk);
        chk("ready_after_resp", req_ready, 1);
    endtask

    task automatic store64(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d,
                           output int cyc, output bit was_err);
        req_addr_64  = a;
        req_size_64  = s;
        req_wdata_64 = d;
        req_valid_64 = 1'b1;
        @(posedge clk);
        #1;
        req_valid_64 = 1'b0;
        cyc          = 0;
        was_err      = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done_64 || err_64) begin
                cyc     = i;
                was_err = err_64;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit e;
        int rd0, wr0, rq0, dn0;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_wdata    = '0;
        mem_rdata    = '0;
        req_valid_64 = 1'b0;
        req_addr_64  = '0;
        req_size_64  = '0;
        req_wdata_64 = '0;
        mem_gnt_64   = 1'b1;
        mem_rvalid_64 = 1'b0;
        mem_rdata_64 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy",      busy,      0);
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_done_err",  {done, err}, 0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Byte store into a 32-bit word
        mem_word = 32'h1122_3344;
        rd0 = n_rd; wr0 = n_wr;
        store32(32'h102, 2'b00, 32'h0000_00AB, cyc, e);
        chk("b_cycle", cyc, 4);
        chk("b_err",   e,   0);
        chk("b_raddr", last_raddr, 32'h100);
        chk("b_waddr", last_waddr, 32'h100);
        chk("b_wdata", last_wdata, 32'h11AB_3344);
        chk("b_nrdwr", {32'(n_rd - rd0), 32'(n_wr - wr0)}, {32'd1, 32'd1});

        // Half store, then a misaligned half
        mem_word = 32'hCAFE_F00D;
        store32(32'h206, 2'b01, 32'h0000_BEEF, cyc, e);
        chk("h_cycle", cyc, 4);
        chk("h_waddr", last_waddr, 32'h204);
        chk("h_wdata", last_wdata, 32'hBEEF_F00D);
        rq0 = n_reqcyc;
        store32(32'h205, 2'b01, 32'h0000_1234, cyc, e);
        chk("mis_cycle", cyc, 1);
        chk("mis_err",   e,   1);
        chk("mis_noreq", n_reqcyc - rq0, 0);

        // Full-width word store: direct write, no read
        rd0 = n_rd; wr0 = n_wr;
        store32(32'h300, 2'b10, 32'hDEAD_BEEF, cyc, e);
        chk("w_cycle", cyc, 2);
        chk("w_err",   e,   0);
        chk("w_nrdwr", {32'(n_rd - rd0), 32'(n_wr - wr0)}, {32'd0, 32'd1});
        chk("w_waddr", last_waddr, 32'h300);
        chk("w_wdata", last_wdata, 32'hDEAD_BEEF);

        // Double on a 32-bit unit is illegal
        rq0 = n_reqcyc;
        store32(32'h300, 2'b11, 32'h0, cyc, e);
        chk("d32_cycle", cyc, 1);
        chk("d32_err",   e,   1);
        chk("d32_noreq", n_reqcyc - rq0, 0);

        // Stalled grants and slow read data
        gnt_stall = 3; rv_lat = 4;
        mem_word  = 32'h1122_3344;
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done; n_unstable = 0;
        store32(32'h101, 2'b00, 32'h0000_005A, cyc, e);
        chk("st_cycle",    cyc, 13);
        chk("st_wdata",    last_wdata, 32'h1122_5A44);
        chk("st_waddr",    last_waddr, 32'h100);
        chk("st_nrdwr",    {32'(n_rd - rd0), 32'(n_wr - wr0)}, {32'd1, 32'd1});
        chk("st_ndone",    n_done - dn0, 1);
        chk("st_unstable", n_unstable, 0);

        // Reset while waiting for read data
        gnt_stall = 0; rv_lat = 4;
        wr0 = n_wr; dn0 = n_done;
        req_addr = 32'h102; req_size = 2'b00; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rw_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_mem_req", mem_req,   0);
        chk("rw_ready",   req_ready, 1);
        chk("rw_busy",    busy,      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rw_nowrite", n_wr - wr0,   0);
        chk("rw_nodone",  n_done - dn0, 0);

        // Reset while a write is stalled: request must vanish at once
        gnt_stall = 3; rv_lat = 1;
        wr0 = n_wr;
        req_addr = 32'h400; req_size = 2'b10; req_wdata = 32'h0BAD_F00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("ww_req_pre", {mem_req, mem_we}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("ww_mem_req", mem_req, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("ww_nowrite", n_wr - wr0, 0);

        // Fresh request after reset completes normally
        gnt_stall = 0; rv_lat = 1;
        mem_word  = 32'hAABB_CCDD;
        store32(32'h10C, 2'b01, 32'h0000_1234, cyc, e);
        chk("pr_cycle", cyc, 4);
        chk("pr_waddr", last_waddr, 32'h10C);
        chk("pr_wdata", last_wdata, 32'hAABB_1234);

        // 64-bit instance: word into upper half, then a direct double store
        mem_word64 = 64'h0011_2233_4455_6677;
        rd0 = n_rd64; wr0 = n_wr64;
        store64(32'h1004, 2'b10, 64'h0000_0000_5566_7788, cyc, e);
        chk("x64w_cycle", cyc, 4);
        chk("x64w_waddr", last_waddr64, 32'h1000);
        chk("x64w_wdata", last_wdata64, 64'h5566_7788_4455_6677);
        chk("x64w_nrd",   n_rd64 - rd0, 1);
        rd0 = n_rd64;
        store64(32'h1008, 2'b11, 64'h0123_4567_89AB_CDEF, cyc, e);
        chk("x64d_cycle", cyc, 2);
        chk("x64d_err",   e,   0);
        chk("x64d_nrd",   n_rd64 - rd0, 0);
        chk("x64d_waddr", last_waddr64, 32'h1008);
        chk("x64d_wdata", last_wdata64, 64'h0123_4567_89AB_CDEF);
        store64(32'h100C, 2'b10, 64'h1, cyc, e);
        chk("x64mis_cycle", cyc, 4);
        store64(32'h1002, 2'b10, 64'h1, cyc, e);
        chk("x64bad_err", {32'(cyc), 32'(e)}, {32'd1, 32'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
